// File: rtl/packet_assembler_q_if.sv
// Packet source handshake bundle for packet_assembler_q.
//   pkt_valid : source offers a header/subpacket set
//   pkt_ready : assembler FIFO can accept (transfer = pkt_valid & pkt_ready)
//   header    : HB0..HB2, bit 0 sent first
//   sub       : subpacket k at [56k +: 56]
// master = packet source, slave = assembler.
interface packet_assembler_q_if #(
  parameter int unsigned NUM_SUB = 4
);
  logic                   pkt_valid;
  logic                   pkt_ready;
  logic [23:0]            header;
  logic [56*NUM_SUB-1:0]  sub;

  modport master (
    output pkt_valid,
    output header,
    output sub,
    input  pkt_ready
  );

  modport slave (
    input  pkt_valid,
    input  header,
    input  sub,
    output pkt_ready
  );
endinterface

// File: rtl/packet_assembler_q.sv
// HDMI data-island packet assembler.
// Queues header/subpacket sets in a small FIFO and serialises one packet per 32 active
// clk_pixel cycles with bit-serial BCH ECC appended; sends a NULL packet when the queue is empty.
// Ports:
//   clk_pixel, reset_n : pixel clock, asynchronous active-low reset
//   island_active      : data-island period
//   pkt_if (slave)     : pkt_valid/pkt_ready/header/sub packet source
//   packet_data        : {sub odd bits, sub even bits, header bit} for the current bit index
//   counter            : bit index within the current packet
//   pkt_start/null_sent: packet load pulse / load was a NULL packet
//   island_full        : MAX_PKTS packets started in this island
//   aborted            : island ended mid-packet (one-cycle pulse)
module packet_assembler_q #(
  parameter int unsigned NUM_SUB  = 4,
  parameter int unsigned DEPTH    = 2,
  parameter logic [7:0]  ECC_POLY = 8'h83,
  parameter int unsigned MAX_PKTS = 18
) (
  input  logic                clk_pixel,
  input  logic                reset_n,
  input  logic                island_active,
  packet_assembler_q_if.slave pkt_if,
  output logic [2*NUM_SUB:0]  packet_data,
  output logic [4:0]          counter,
  output logic                pkt_start,
  output logic                null_sent,
  output logic                island_full,
  output logic                aborted
);
  localparam int unsigned SubW = 56 * NUM_SUB;
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(MAX_PKTS + 1);

  function automatic logic [7:0] ecc_step(input logic [7:0] ecc, input logic data_bit);
    return (ecc >> 1) ^ ((ecc[0] ^ data_bit) ? ECC_POLY : 8'h00);
  endfunction

  logic [23:0]            fifo_hdr_q [DEPTH];
  logic [SubW-1:0]        fifo_sub_q [DEPTH];
  logic [PtrW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]             counter_q, counter_d;
  logic [23:0]            hdr_q, hdr_d;
  logic [SubW-1:0]        sub_q, sub_d;
  logic [7:0]             hpar_q, hpar_d;
  logic [NUM_SUB-1:0][7:0] spar_q, spar_d;
  logic [CntW-1:0]        starts_q, starts_d;
  logic                   aborted_q, aborted_d;

  logic                   fifo_empty, fifo_full, push, pop, act, start;
  logic [23:0]            load_hdr, cur_hdr;
  logic [SubW-1:0]        load_sub, cur_sub;
  logic [31:0]            hdr_stream;
  logic                   hdr_bit;
  logic [NUM_SUB-1:0][1:0] sub_pair;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  assign pkt_if.pkt_ready = reset_n & ~fifo_full;
  assign push  = pkt_if.pkt_valid & pkt_if.pkt_ready;
  assign act   = island_active & reset_n;
  assign start = act & (counter_q == 5'd0);
  // A pop in the same cycle as a push into an empty FIFO sees empty and sends NULL.
  assign pop   = start & ~fifo_empty;

  assign load_hdr = fifo_empty ? 24'h0 : fifo_hdr_q[rd_ptr_q[PtrW-1:0]];
  assign load_sub = fifo_empty ? '0    : fifo_sub_q[rd_ptr_q[PtrW-1:0]];
  // Bypass the load so the new packet's bit 0 goes out on the load cycle itself.
  assign cur_hdr  = start ? load_hdr : hdr_q;
  assign cur_sub  = start ? load_sub : sub_q;

  // Each lane is a stream {parity, data}; parity bits only ever read once fully accumulated.
  assign hdr_stream = {hpar_q, cur_hdr};
  assign hdr_bit    = hdr_stream[counter_q];

  always_comb begin
    for (int unsigned k = 0; k < NUM_SUB; k++) begin
      sub_pair[k] = 2'({spar_q[k], cur_sub[56*k +: 56]} >> {counter_q, 1'b0});
    end
  end

  always_comb begin
    counter_d = act ? counter_q + 5'd1 : 5'd0;
    hdr_d     = start ? load_hdr : hdr_q;
    sub_d     = start ? load_sub : sub_q;
    wr_ptr_d  = wr_ptr_q + {{PtrW{1'b0}}, push};
    rd_ptr_d  = rd_ptr_q + {{PtrW{1'b0}}, pop};
    hpar_d    = hpar_q;
    spar_d    = spar_q;
    if (!act || counter_q == 5'd31) begin
      hpar_d = 8'h00;
      spar_d = '0;
    end else begin
      if (counter_q < 5'd24) hpar_d = ecc_step(hpar_q, hdr_bit);
      if (counter_q < 5'd28) begin
        for (int unsigned k = 0; k < NUM_SUB; k++) begin
          spar_d[k] = ecc_step(ecc_step(spar_q[k], sub_pair[k][0]), sub_pair[k][1]);
        end
      end
    end
    starts_d = starts_q;
    if (!act) begin
      starts_d = '0;
    end else if (start && starts_q != CntW'(MAX_PKTS)) begin
      starts_d = starts_q + CntW'(1);
    end
    aborted_d = ~island_active & (counter_q != 5'd0);
  end

  always_comb begin
    packet_data = '0;
    if (act) begin
      packet_data[0] = hdr_bit;
      for (int unsigned k = 0; k < NUM_SUB; k++) begin
        packet_data[1 + k]           = sub_pair[k][0];
        packet_data[1 + NUM_SUB + k] = sub_pair[k][1];
      end
    end
  end

  assign counter     = counter_q;
  assign pkt_start   = start;
  assign null_sent   = start & fifo_empty;
  assign island_full = (starts_q == CntW'(MAX_PKTS));
  assign aborted     = aborted_q;

  // Storage needs no reset; emptiness is carried by the pointers.
  always_ff @(posedge clk_pixel) begin
    if (push) begin
      fifo_hdr_q[wr_ptr_q[PtrW-1:0]] <= pkt_if.header;
      fifo_sub_q[wr_ptr_q[PtrW-1:0]] <= pkt_if.sub;
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      counter_q <= 5'd0;
      hdr_q     <= 24'h0;
      sub_q     <= '0;
      hpar_q    <= 8'h00;
      spar_q    <= '0;
      starts_q  <= '0;
      aborted_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      counter_q <= counter_d;
      hdr_q     <= hdr_d;
      sub_q     <= sub_d;
      hpar_q    <= hpar_d;
      spar_q    <= spar_d;
      starts_q  <= starts_d;
      aborted_q <= aborted_d;
    end
  end
endmodule
